// File: rtl/video_timing_pkg.sv
// Shared types and constants for the parametrised video timing generator:
// pattern mode encodings, colour-bar palette and RGB444 expansion.
package video_timing_pkg;

   typedef enum logic [1:0] {
      MODE_FB    = 2'd0,
      MODE_BARS  = 2'd1,
      MODE_SOLID = 2'd2,
      MODE_GRID  = 2'd3
   } mode_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
   localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
   localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
   localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
   localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
   localparam logic [23:0] BAR_RED     = 24'hFF0000;
   localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
   localparam logic [23:0] BAR_BLACK   = 24'h000000;

   // Everything about a pixel that must travel alongside the SRAM read.
   typedef struct packed {
      logic        active;
      logic        hs;
      logic        vs;
      logic        fs;
      mode_t       mode;
      logic [2:0]  bar;
      logic        grid;
      logic [23:0] solid;
   } ctrl_t;

   function automatic logic [23:0] rgb444_to_888(input logic [11:0] c);
      return {c[11:8], c[11:8], c[7:4], c[7:4], c[3:0], c[3:0]};
   endfunction

   function automatic logic [23:0] bar_color(input logic [2:0] idx);
      logic [23:0] col;
      case (idx)
         3'd0:    col = BAR_WHITE;
         3'd1:    col = BAR_YELLOW;
         3'd2:    col = BAR_CYAN;
         3'd3:    col = BAR_GREEN;
         3'd4:    col = BAR_MAGENTA;
         3'd5:    col = BAR_RED;
         3'd6:    col = BAR_BLUE;
         default: col = BAR_BLACK;
      endcase
      return col;
   endfunction

endpackage

// File: rtl/video_delay_line.sv
// Fixed-depth shift register with a synchronous clear to a parameterised
// value; carries the per-pixel control bundle across the SRAM read latency.
module video_delay_line #(
   parameter int               WIDTH = 8,
   parameter int               DEPTH = 2,
   parameter logic [WIDTH-1:0] INIT  = '0
) (
   input  logic             clk,
   input  logic             clr,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] sr [DEPTH];

   always_ff @(posedge clk) begin
      if (clr) begin
         for (int i = 0; i < DEPTH; i++) sr[i] <= INIT;
      end else begin
         sr[0] <= din;
         for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
      end
   end

   assign dout = sr[DEPTH-1];

endmodule

// File: rtl/video_timing_gen_param.sv
// Parametrised raster timing generator: h/v counters, frame-buffer read
// addressing with integer upscale, test patterns, and latency-aligned outputs.
module video_timing_gen_param
   import video_timing_pkg::*;
#(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0,
   parameter int SCALE_SH = 1,
   parameter int RD_LAT   = 2,
   parameter int ADDR_W   = 17,
   parameter int CNT_W    = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic [1:0]        mode,
   input  logic [23:0]       solid_color,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [11:0]       rd_data,
   output logic              hsync,
   output logic              vsync,
   output logic              de,
   output logic [23:0]       rgb_data,
   output logic              frame_start,
   output logic [CNT_W-1:0]  h_count,
   output logic [CNT_W-1:0]  v_count
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int SRC_W   = H_ACTIVE >> SCALE_SH;
   localparam int CTRL_W  = $bits(ctrl_t);

   localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] HS_BEG_C = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] HS_END_C = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CNT_W-1:0] VS_BEG_C = CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0] VS_END_C = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

   if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
      $error("video_timing_gen_param: RD_LAT must be in 1..4");
   end

   state_t            state_q, state_d;
   logic              running;
   logic              at_origin;
   logic              active, hs_raw, vs_raw, grid_raw;
   logic [2:0]        bar_idx;
   mode_t             mode_q, mode_cur;
   logic [ADDR_W-1:0] addr_calc;
   ctrl_t             ctrl_in, ctrl_d;
   logic [23:0]       pix;

   // ---------------- run/idle control ----------------
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (enable)  state_d = ST_RUN;
         ST_RUN:  if (!enable) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // The clock that first sees enable only moves to RUN; counting starts next.
   assign running = (state_q == ST_RUN) && enable;

   // ---------------- raster counters ----------------
   always_ff @(posedge clk) begin
      if (rst || !enable) begin
         h_count <= '0;
         v_count <= '0;
      end else if (state_q == ST_RUN) begin
         if (h_count == H_LAST) begin
            h_count <= '0;
            v_count <= (v_count == V_LAST) ? '0 : v_count + CNT_W'(1);
         end else begin
            h_count <= h_count + CNT_W'(1);
         end
      end
   end

   assign at_origin = (h_count == '0) && (v_count == '0);
   assign active    = (h_count < H_ACT_C) && (v_count < V_ACT_C);
   assign hs_raw    = (h_count >= HS_BEG_C) && (h_count < HS_END_C);
   assign vs_raw    = (v_count >= VS_BEG_C) && (v_count < VS_END_C);
   assign grid_raw  = (h_count[4:0] == 5'd0) || (v_count[4:0] == 5'd0);

   // Mode is latched at the frame origin so a whole frame uses one pattern.
   assign mode_cur = at_origin ? mode_t'(mode) : mode_q;

   always_ff @(posedge clk) begin
      if (rst)            mode_q <= MODE_FB;
      else if (at_origin) mode_q <= mode_t'(mode);
   end

   // bar index = floor(h*8/H_ACTIVE), as a count of crossed bar boundaries
   always_comb begin
      bar_idx = '0;
      for (int k = 1; k < 8; k++) begin
         if ((32'(h_count) << 3) >= 32'(k * H_ACTIVE)) bar_idx = 3'(k);
      end
   end

   // ---------------- stage 0: SRAM request ----------------
   assign addr_calc = ADDR_W'(v_count >> SCALE_SH) * ADDR_W'(SRC_W)
                    + ADDR_W'(h_count >> SCALE_SH);

   always_ff @(posedge clk) begin
      if (rst || !running) begin
         rd_en   <= 1'b0;
         rd_addr <= '0;
      end else if (active && (mode_cur == MODE_FB)) begin
         rd_en   <= 1'b1;
         rd_addr <= addr_calc;
      end else begin
         rd_en   <= 1'b0;
         rd_addr <= '0;
      end
   end

   // ---------------- control pipeline ----------------
   always_comb begin
      ctrl_in        = '0;
      ctrl_in.active = active;
      ctrl_in.hs     = hs_raw;
      ctrl_in.vs     = vs_raw;
      ctrl_in.fs     = active && at_origin;
      ctrl_in.mode   = mode_cur;
      ctrl_in.bar    = bar_idx;
      ctrl_in.grid   = grid_raw;
      ctrl_in.solid  = solid_color;
   end

   // Depth RD_LAT+1 lands the bundle beside rd_data at the output register.
   video_delay_line #(
      .WIDTH (CTRL_W),
      .DEPTH (RD_LAT + 1),
      .INIT  ('0)
   ) u_ctrl_dly (
      .clk  (clk),
      .clr  (rst || !running),
      .din  (ctrl_in),
      .dout (ctrl_d)
   );

   // ---------------- output stage ----------------
   always_comb begin
      pix = '0;
      if (ctrl_d.active) begin
         case (ctrl_d.mode)
            MODE_FB:    pix = rgb444_to_888(rd_data);
            MODE_BARS:  pix = bar_color(ctrl_d.bar);
            MODE_SOLID: pix = ctrl_d.solid;
            MODE_GRID:  pix = ctrl_d.grid ? BAR_WHITE : BAR_BLACK;
            default:    pix = '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst || !running) begin
         hsync       <= !HS_POL;
         vsync       <= !VS_POL;
         de          <= 1'b0;
         rgb_data    <= '0;
         frame_start <= 1'b0;
      end else begin
         hsync       <= ctrl_d.hs ^ !HS_POL;
         vsync       <= ctrl_d.vs ^ !VS_POL;
         de          <= ctrl_d.active;
         rgb_data    <= pix;
         frame_start <= ctrl_d.fs;
      end
   end

endmodule

// File: tb/tb_video_timing_gen_param.sv
// Directed bench for video_timing_gen_param: four parameterisations exercising
// timing, addressing, data alignment, patterns, enable/reset and polarity.
`timescale 1ns/1ps
module tb_video_timing_gen_param;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [11:0] sram_word(input logic [16:0] a);
      return a[11:0] ^ 12'hA5C;
   endfunction

   function automatic logic [23:0] expand12(input logic [11:0] c);
      return {{2{c[11:8]}}, {2{c[7:4]}}, {2{c[3:0]}}};
   endfunction

   function automatic bit s_act(input int h, input int v);
      return (h < 8) && (v < 4);
   endfunction

   logic        rst_a, rst_d;
   logic        en_s, en_d, en_p;
   logic [1:0]  mode_s, mode_d, mode_p;
   logic [23:0] solid_d;

   logic        s_rd_en, s_hs, s_vs, s_de, s_fs;
   logic [16:0] s_addr;
   logic [11:0] s_rdata, s_hc, s_vc, s_pipe0, s_pipe1;
   logic [23:0] s_rgb;

   logic        q_rd_en, q_hs, q_vs, q_de, q_fs;
   logic [16:0] q_addr;
   logic [11:0] q_hc, q_vc;
   logic [23:0] q_rgb;

   logic        d_rd_en, d_hs, d_vs, d_de, d_fs;
   logic [16:0] d_addr;
   logic [11:0] d_hc, d_vc;
   logic [23:0] d_rgb;

   logic        p_rd_en, p_hs, p_vs, p_de, p_fs;
   logic [16:0] p_addr;
   logic [11:0] p_hc, p_vc;
   logic [23:0] p_rgb;

   // SRAM model for the small-timing DUT: two-clock latency, address-dependent data
   always @(posedge clk) begin
      s_pipe0 <= sram_word(s_addr);
      s_pipe1 <= s_pipe0;
   end
   assign s_rdata = s_pipe1;

   video_timing_gen_param #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .SCALE_SH(0), .RD_LAT(2)
   ) dut_s (
      .clk(clk), .rst(rst_a), .enable(en_s), .mode(mode_s), .solid_color(24'h0),
      .rd_en(s_rd_en), .rd_addr(s_addr), .rd_data(s_rdata),
      .hsync(s_hs), .vsync(s_vs), .de(s_de), .rgb_data(s_rgb),
      .frame_start(s_fs), .h_count(s_hc), .v_count(s_vc)
   );

   video_timing_gen_param #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .SCALE_SH(0), .RD_LAT(1)
   ) dut_q (
      .clk(clk), .rst(rst_a), .enable(en_s), .mode(mode_s), .solid_color(24'h0),
      .rd_en(q_rd_en), .rd_addr(q_addr), .rd_data(12'hF80),
      .hsync(q_hs), .vsync(q_vs), .de(q_de), .rgb_data(q_rgb),
      .frame_start(q_fs), .h_count(q_hc), .v_count(q_vc)
   );

   video_timing_gen_param #(
      .V_ACTIVE(8), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .SCALE_SH(1), .RD_LAT(3)
   ) dut_d (
      .clk(clk), .rst(rst_d), .enable(en_d), .mode(mode_d), .solid_color(solid_d),
      .rd_en(d_rd_en), .rd_addr(d_addr), .rd_data(12'hF80),
      .hsync(d_hs), .vsync(d_vs), .de(d_de), .rgb_data(d_rgb),
      .frame_start(d_fs), .h_count(d_hc), .v_count(d_vc)
   );

   video_timing_gen_param #(
      .V_ACTIVE(16), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HS_POL(1'b1), .VS_POL(1'b1), .SCALE_SH(2), .RD_LAT(2)
   ) dut_p (
      .clk(clk), .rst(rst_a), .enable(en_p), .mode(mode_p), .solid_color(24'h0),
      .rd_en(p_rd_en), .rd_addr(p_addr), .rd_data(12'h0F0),
      .hsync(p_hs), .vsync(p_vs), .de(p_de), .rgb_data(p_rgb),
      .frame_start(p_fs), .h_count(p_hc), .v_count(p_vc)
   );

   initial begin
      int h, v, oh, ov, s, n;
      int hs_low, vs_low, de_hi;
      bit found;
      logic e_en, e_de, e_hs, e_vs, e_fs;
      logic [16:0] e_addr;
      logic [23:0] e_rgb;

      rst_a = 1'b1; rst_d = 1'b1;
      en_s = 1'b0; en_d = 1'b0; en_p = 1'b0;
      mode_s = 2'd0; mode_d = 2'd0; mode_p = 2'd0; solid_d = 24'h0;
      hs_low = 0; vs_low = 0; de_hi = 0;
      repeat (3) @(posedge clk);

      // ---------------- reset state ----------------
      @(negedge clk);
      check("rst h_count", s_hc, 0);
      check("rst v_count", s_vc, 0);
      check("rst hsync", s_hs, 1);
      check("rst vsync", s_vs, 1);
      check("rst de", s_de, 0);
      check("rst rgb", s_rgb, 0);
      check("rst rd_en", s_rd_en, 0);
      check("rst rd_addr", s_addr, 0);
      check("rst frame_start", s_fs, 0);
      check("rst pol hsync", p_hs, 0);
      check("rst pol vsync", p_vs, 0);
      rst_a = 1'b0; rst_d = 1'b0;
      @(negedge clk);
      check("idle h_count", s_hc, 0);
      check("idle pol hsync", p_hs, 0);
      en_s = 1'b1;
      @(posedge clk);

      // ---------------- small timing, per-cycle model ----------------
      for (int t = 0; t < 202; t++) begin
         @(negedge clk);
         h = t % 14;
         v = (t / 14) % 7;
         check($sformatf("s h_count t=%0d", t), s_hc, h);
         check($sformatf("s v_count t=%0d", t), s_vc, v);
         e_en = 1'b0;
         e_addr = '0;
         if (t >= 1) begin
            oh = (t - 1) % 14;
            ov = ((t - 1) / 14) % 7;
            e_en = s_act(oh, ov);
            if (e_en) e_addr = 17'(ov * 8 + oh);
         end
         check($sformatf("s rd_en t=%0d", t), s_rd_en, e_en);
         check($sformatf("s rd_addr t=%0d", t), s_addr, e_addr);
         s = t - 4;
         e_de = 1'b0; e_hs = 1'b1; e_vs = 1'b1; e_fs = 1'b0; e_rgb = '0;
         if (s >= 0) begin
            oh = s % 14;
            ov = (s / 14) % 7;
            e_de = s_act(oh, ov);
            e_hs = !(oh >= 10 && oh <= 11);
            e_vs = !(ov == 5);
            e_fs = (oh == 0) && (ov == 0);
            if (e_de) e_rgb = expand12(sram_word(17'(ov * 8 + oh)));
         end
         check($sformatf("s hsync t=%0d", t), s_hs, e_hs);
         check($sformatf("s vsync t=%0d", t), s_vs, e_vs);
         check($sformatf("s de t=%0d", t), s_de, e_de);
         check($sformatf("s frame_start t=%0d", t), s_fs, e_fs);
         check($sformatf("s rgb t=%0d", t), s_rgb, e_rgb);
         if (t >= 102 && t < 200) begin
            hs_low += (s_hs == 1'b0) ? 1 : 0;
            vs_low += (s_vs == 1'b0) ? 1 : 0;
            de_hi  += (s_de == 1'b1) ? 1 : 0;
         end
         // RD_LAT=1 twin: same timing, constant SRAM word
         case (t)
            1: begin
               check("q rd_en first", q_rd_en, 1);
               check("q rd_addr first", q_addr, 0);
            end
            2: begin
               check("q de before", q_de, 0);
               check("q rd_addr second", q_addr, 1);
            end
            3: begin
               check("q de rise", q_de, 1);
               check("q rgb at de rise", q_rgb, 24'hFF8800);
               check("q frame_start", q_fs, 1);
               check("q hsync", q_hs, 1);
               check("q vsync", q_vs, 1);
               check("q h_count", q_hc, 3);
               check("q v_count", q_vc, 0);
            end
            default: ;
         endcase
      end
      check("s hsync low per frame", hs_low, 14);
      check("s vsync low per frame", vs_low, 14);
      check("s de high per frame", de_hi, 32);
      en_s = 1'b0;

      // ---------------- default H timing, RD_LAT=3, 2x upscale ----------------
      @(negedge clk);
      en_d = 1'b1;
      @(posedge clk);
      for (int t = 0; t <= 17900; t++) begin
         @(negedge clk);
         case (t)
            4:     check("d de before", d_de, 0);
            5: begin
               check("d de rise", d_de, 1);
               check("d rgb at de rise", d_rgb, 24'hFF8800);
               check("d frame_start", d_fs, 1);
            end
            100:   mode_d = 2'd1;
            805:   check("d frame0 still fb", d_rgb, 24'hFF8800);
            4004: begin
               check("d rd_en (3,5)", d_rd_en, 1);
               check("d rd_addr (3,5)", d_addr, 641);
            end
            6240:  check("d rd_addr (639,7)", d_addr, 1279);
            6241: begin
               check("d rd_en h=640", d_rd_en, 0);
               check("d rd_addr h=640", d_addr, 0);
            end
            8801:  check("d rd_en in bars", d_rd_en, 0);
            8805: begin
               check("d bars frame_start", d_fs, 1);
               check("d bar h=0", d_rgb, 24'hFFFFFF);
            end
            8806:  check("d frame_start pulse", d_fs, 0);
            8884:  check("d bar h=79", d_rgb, 24'hFFFFFF);
            8885:  check("d bar h=80", d_rgb, 24'hFFFF00);
            9000: begin
               mode_d = 2'd2;
               solid_d = 24'h123456;
            end
            9205:  check("d bar h=400", d_rgb, 24'hFF0000);
            9444: begin
               check("d bar h=639", d_rgb, 24'h000000);
               check("d de h=639", d_de, 1);
            end
            9605:  check("d mid-frame mode held", d_rgb, 24'hFFFFFF);
            17605: begin
               check("d solid frame_start", d_fs, 1);
               check("d solid rgb", d_rgb, 24'h123456);
            end
            17900: begin
               check("d de before drop", d_de, 1);
               en_d = 1'b0;
            end
            default: ;
         endcase
      end
      @(negedge clk);
      check("drop h_count", d_hc, 0);
      check("drop v_count", d_vc, 0);
      check("drop de", d_de, 0);
      check("drop hsync", d_hs, 1);
      check("drop rgb", d_rgb, 0);
      check("drop rd_en", d_rd_en, 0);

      en_d = 1'b1;
      @(posedge clk);
      n = 0;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(posedge clk);
         #1;
         n++;
         if (d_fs) found = 1'b1;
      end
      check("restart frame_start latency", n, 5);
      repeat (100) @(negedge clk);
      check("d de before rst", d_de, 1);
      rst_d = 1'b1;
      @(negedge clk);
      check("rst mid h_count", d_hc, 0);
      check("rst mid v_count", d_vc, 0);
      check("rst mid de", d_de, 0);
      check("rst mid hsync", d_hs, 1);
      check("rst mid vsync", d_vs, 1);
      check("rst mid rgb", d_rgb, 0);
      check("rst mid rd_en", d_rd_en, 0);
      check("rst mid frame_start", d_fs, 0);
      rst_d = 1'b0;
      en_d = 1'b0;

      // ---------------- positive polarity, 4x upscale ----------------
      @(negedge clk);
      en_p = 1'b1;
      @(posedge clk);
      for (int t = 0; t <= 13604; t++) begin
         @(negedge clk);
         case (t)
            4: begin
               check("p de first", p_de, 1);
               check("p rgb first", p_rgb, 24'h00FF00);
               check("p frame_start", p_fs, 1);
            end
            659:   check("p hsync before", p_hs, 0);
            660:   check("p hsync start", p_hs, 1);
            755:   check("p hsync last", p_hs, 1);
            756:   check("p hsync after", p_hs, 0);
            7208: begin
               check("p rd_addr (7,9)", p_addr, 321);
               check("p rd_en (7,9)", p_rd_en, 1);
               check("p h_count", p_hc, 8);
               check("p v_count", p_vc, 9);
            end
            13603: check("p vsync before", p_vs, 0);
            13604: check("p vsync start", p_vs, 1);
            default: ;
         endcase
      end
      en_p = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
